// File: rtl/vid_crop_pkg.sv
// Shared constants for the video cropper and its position tracker.
package vid_crop_pkg;

  // Drop-state encoding: RUN passes windowed pixels, DROP discards the rest
  // of a malformed frame until the next frame start.
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_DROP = 1'b1;

  // Sync-convention selector value meaning TUSER=start-of-frame, TLAST=HLAST.
  // Any other value means TUSER=HLAST, TLAST=end-of-frame.
  localparam int MODE_SOF_USER = 1;

endpackage

// File: rtl/vid_pos.sv
// Input position tracker for an AXI video stream.
// Reports the (x, y) position of the beat currently on the bus, whether it is
// a frame start, and the line/frame markers decoded from TLAST/TUSER.
// In SOF mode it also stays idle until the first TUSER beat, and flags the
// start-of-frame beat that implicitly ends the previous frame.
module vid_pos
  import vid_crop_pkg::*;
#(
  parameter int LGDIM            = 11,
  parameter int OPT_TUSER_IS_SOF = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             beat_i,
  input  logic             last_i,
  input  logic             user_i,
  output logic             track_o,
  output logic             start_o,
  output logic             hlast_o,
  output logic             eof_o,
  output logic             prev_eof_o,
  output logic [LGDIM-1:0] x_o,
  output logic [LGDIM-1:0] y_o,
  output logic [LGDIM-1:0] prev_y_o
);

  logic [LGDIM-1:0] x_q, x_d;
  logic [LGDIM-1:0] y_q, y_d;
  logic [LGDIM-1:0] prevY_q, prevY_d;
  logic             synced_q, synced_d;

  // Decode the current beat: its effective position and its sync meaning.
  always_comb begin
    track_o    = 1'b1;
    start_o    = (x_q == '0) && (y_q == '0);
    hlast_o    = user_i;
    eof_o      = last_i;
    prev_eof_o = 1'b0;
    x_o        = x_q;
    y_o        = y_q;
    if (OPT_TUSER_IS_SOF == MODE_SOF_USER) begin
      track_o    = synced_q || user_i;
      start_o    = user_i;
      hlast_o    = last_i;
      eof_o      = 1'b0;
      prev_eof_o = user_i && synced_q;
      if (user_i) begin
        x_o = '0;
        y_o = '0;
      end
    end
  end

  // Advance the position after each tracked beat.
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    prevY_d  = prevY_q;
    synced_d = synced_q;
    if (beat_i && track_o) begin
      synced_d = 1'b1;
      prevY_d  = y_o;
      if (eof_o) begin
        x_d = '0;
        y_d = '0;
      end else if (hlast_o) begin
        x_d = '0;
        y_d = y_o + LGDIM'(1);
      end else begin
        x_d = x_o + LGDIM'(1);
        y_d = y_o;
      end
    end
  end

  // Position registers; reset puts the tracker at the start of a frame.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      x_q      <= '0;
      y_q      <= '0;
      prevY_q  <= '0;
      synced_q <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      prevY_q  <= prevY_d;
      synced_q <= synced_d;
    end
  end

  assign prev_y_o = prevY_q;

endmodule

// File: rtl/vid_crop.sv
// AXI video stream cropper. Passes only pixels inside a programmable window
// and regenerates line/frame sync so the output is a well-formed smaller
// frame. The window is latched on each input frame start; malformed input
// (short line or short frame) raises a sticky error and the remainder of a
// short-lined frame is discarded.
module vid_crop
  import vid_crop_pkg::*;
#(
  parameter int LGDIM            = 11,
  parameter int PW               = 24,
  parameter int OPT_TUSER_IS_SOF = 0
) (
  input  logic             S_AXI_ACLK,
  input  logic             S_AXI_ARESETN,
  input  logic             S_VID_VALID,
  output logic             S_VID_READY,
  input  logic [PW-1:0]    S_VID_DATA,
  input  logic             S_VID_LAST,
  input  logic             S_VID_USER,
  output logic             M_VID_VALID,
  input  logic             M_VID_READY,
  output logic [PW-1:0]    M_VID_DATA,
  output logic             M_VID_LAST,
  output logic             M_VID_USER,
  input  logic [LGDIM-1:0] i_xoff,
  input  logic [LGDIM-1:0] i_yoff,
  input  logic [LGDIM-1:0] i_width,
  input  logic [LGDIM-1:0] i_height,
  output logic             o_err
);

  localparam int DW = LGDIM + 1;

  logic             outLoad;
  logic             accept;
  logic             tracked;

  logic             posTrack, posStart, posHlast, posEof, posPrevEof;
  logic [LGDIM-1:0] posX, posY, posPrevY;

  logic [LGDIM-1:0] cfgXoff_q, cfgYoff_q, cfgWidth_q, cfgHeight_q;
  logic [LGDIM-1:0] cfgXoff_d, cfgYoff_d, cfgWidth_d, cfgHeight_d;
  logic [LGDIM-1:0] effXoff, effYoff, effWidth, effHeight;

  logic [DW-1:0]    xEnd, yEnd, xNext, yNext, oldYEnd, prevYNext;
  logic             sizeOk, oldSizeOk, inCols, inRows;
  logic             dropNow, emit;
  logic             lineErr, frameErr, seamErr;
  logic             oHlast, oVlast, oSof;

  logic [0:0]       state_q, state_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  logic [PW-1:0]    data_q, data_d;
  logic             last_q, last_d;
  logic             user_q, user_d;

  assign outLoad     = !valid_q || M_VID_READY;
  assign S_VID_READY = outLoad;
  assign accept      = S_VID_VALID && outLoad;
  assign tracked     = accept && posTrack;

  vid_pos #(
    .LGDIM           (LGDIM),
    .OPT_TUSER_IS_SOF(OPT_TUSER_IS_SOF)
  ) u_pos (
    .clk_i     (S_AXI_ACLK),
    .rst_ni    (S_AXI_ARESETN),
    .beat_i    (accept),
    .last_i    (S_VID_LAST),
    .user_i    (S_VID_USER),
    .track_o   (posTrack),
    .start_o   (posStart),
    .hlast_o   (posHlast),
    .eof_o     (posEof),
    .prev_eof_o(posPrevEof),
    .x_o       (posX),
    .y_o       (posY),
    .prev_y_o  (posPrevY)
  );

  // The frame-start beat already belongs to the new frame, so it sees the
  // live config ports; every later beat sees the latched copy.
  always_comb begin
    effXoff   = cfgXoff_q;
    effYoff   = cfgYoff_q;
    effWidth  = cfgWidth_q;
    effHeight = cfgHeight_q;
    if (posStart) begin
      effXoff   = i_xoff;
      effYoff   = i_yoff;
      effWidth  = i_width;
      effHeight = i_height;
    end
  end

  // Window membership, geometry checks and output sync flags, all in
  // LGDIM+1-bit arithmetic so the window end never wraps.
  always_comb begin
    xEnd      = {1'b0, effXoff} + {1'b0, effWidth};
    yEnd      = {1'b0, effYoff} + {1'b0, effHeight};
    xNext     = {1'b0, posX} + DW'(1);
    yNext     = {1'b0, posY} + DW'(1);
    oldYEnd   = {1'b0, cfgYoff_q} + {1'b0, cfgHeight_q};
    prevYNext = {1'b0, posPrevY} + DW'(1);

    sizeOk    = (effWidth != '0) && (effHeight != '0);
    oldSizeOk = (cfgWidth_q != '0) && (cfgHeight_q != '0);
    inCols    = (posX >= effXoff) && ({1'b0, posX} < xEnd);
    inRows    = (posY >= effYoff) && ({1'b0, posY} < yEnd);
    dropNow   = (state_q == ST_DROP) && !posStart;
    emit      = tracked && sizeOk && inCols && inRows && !dropNow;

    lineErr   = tracked && !dropNow && sizeOk && posHlast && inRows && (xNext < xEnd);
    frameErr  = tracked && !dropNow && sizeOk && posEof && (yNext < yEnd);
    seamErr   = accept && posPrevEof && (state_q == ST_RUN) && oldSizeOk
                && (prevYNext < oldYEnd);

    oHlast    = (xNext == xEnd);
    oVlast    = (yNext == yEnd);
    oSof      = (posX == effXoff) && (posY == effYoff);
  end

  // Latch the window on each frame start, and track the drop state and the
  // sticky error flag.
  always_comb begin
    cfgXoff_d   = cfgXoff_q;
    cfgYoff_d   = cfgYoff_q;
    cfgWidth_d  = cfgWidth_q;
    cfgHeight_d = cfgHeight_q;
    state_d     = state_q;
    err_d       = err_q || lineErr || frameErr || seamErr;
    if (tracked) begin
      if (posStart) begin
        cfgXoff_d   = i_xoff;
        cfgYoff_d   = i_yoff;
        cfgWidth_d  = i_width;
        cfgHeight_d = i_height;
      end
      if (lineErr) begin
        state_d = ST_DROP;
      end else if (posStart) begin
        state_d = ST_RUN;
      end
    end
  end

  // Next contents of the output register: load a windowed beat, or empty
  // the register once the downstream stage has taken its beat.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    user_d  = user_q;
    if (outLoad) begin
      valid_d = emit;
      if (emit) begin
        data_d = S_VID_DATA;
        if (OPT_TUSER_IS_SOF == MODE_SOF_USER) begin
          user_d = oSof;
          last_d = oHlast;
        end else begin
          user_d = oHlast;
          last_d = oHlast && oVlast;
        end
      end
    end
  end

  // State registers; reset empties the output and clears the error.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      cfgXoff_q   <= '0;
      cfgYoff_q   <= '0;
      cfgWidth_q  <= '0;
      cfgHeight_q <= '0;
      state_q     <= ST_RUN;
      err_q       <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      last_q      <= 1'b0;
      user_q      <= 1'b0;
    end else begin
      cfgXoff_q   <= cfgXoff_d;
      cfgYoff_q   <= cfgYoff_d;
      cfgWidth_q  <= cfgWidth_d;
      cfgHeight_q <= cfgHeight_d;
      state_q     <= state_d;
      err_q       <= err_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      last_q      <= last_d;
      user_q      <= user_d;
    end
  end

  assign M_VID_VALID = valid_q;
  assign M_VID_DATA  = data_q;
  assign M_VID_LAST  = last_q;
  assign M_VID_USER  = user_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_vid_crop.sv
// Bench for vid_crop: one instance per sync convention, frame-level
// reference model feeding per-instance scoreboards, randomized pixels,
// gaps and output backpressure.
module tb_vid_crop;

  localparam int LGDIM = 11;
  localparam int PW    = 24;

  typedef struct packed {
    logic [PW-1:0] data;
    logic          last;
    logic          user;
  } beat_t;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  logic             s0Valid = 1'b0, s0Ready, s0Last = 1'b0, s0User = 1'b0;
  logic [PW-1:0]    s0Data = '0;
  logic             m0Valid, m0Ready = 1'b1, m0Last, m0User;
  logic [PW-1:0]    m0Data;
  logic [LGDIM-1:0] xoff0 = '0, yoff0 = '0, width0 = '0, height0 = '0;
  logic             err0;

  logic             s1Valid = 1'b0, s1Ready, s1Last = 1'b0, s1User = 1'b0;
  logic [PW-1:0]    s1Data = '0;
  logic             m1Valid, m1Ready = 1'b1, m1Last, m1User;
  logic [PW-1:0]    m1Data;
  logic [LGDIM-1:0] xoff1 = '0, yoff1 = '0, width1 = '0, height1 = '0;
  logic             err1;

  vid_crop #(.LGDIM(LGDIM), .PW(PW), .OPT_TUSER_IS_SOF(0)) dut0 (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rstN),
    .S_VID_VALID(s0Valid), .S_VID_READY(s0Ready), .S_VID_DATA(s0Data),
    .S_VID_LAST(s0Last), .S_VID_USER(s0User),
    .M_VID_VALID(m0Valid), .M_VID_READY(m0Ready), .M_VID_DATA(m0Data),
    .M_VID_LAST(m0Last), .M_VID_USER(m0User),
    .i_xoff(xoff0), .i_yoff(yoff0), .i_width(width0), .i_height(height0),
    .o_err(err0)
  );

  vid_crop #(.LGDIM(LGDIM), .PW(PW), .OPT_TUSER_IS_SOF(1)) dut1 (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rstN),
    .S_VID_VALID(s1Valid), .S_VID_READY(s1Ready), .S_VID_DATA(s1Data),
    .S_VID_LAST(s1Last), .S_VID_USER(s1User),
    .M_VID_VALID(m1Valid), .M_VID_READY(m1Ready), .M_VID_DATA(m1Data),
    .M_VID_LAST(m1Last), .M_VID_USER(m1User),
    .i_xoff(xoff1), .i_yoff(yoff1), .i_width(width1), .i_height(height1),
    .o_err(err1)
  );

  int    checks = 0;
  int    failures = 0;
  beat_t exp0[$];
  beat_t exp1[$];
  logic  expErr0 = 1'b0, expErr1 = 1'b0, pendShort1 = 1'b0;
  int    outCount1 = 0;
  bit    bp0 = 1'b0, bp1 = 1'b0, gapOn = 1'b0;
  int    lineLens[$];

  // One comparison: count it, report it if it differs.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Downstream ready: always ready, or random stalls when backpressure is on.
  always @(posedge clk) begin
    #1;
    m0Ready = bp0 ? 1'($urandom_range(0, 1)) : 1'b1;
    m1Ready = bp1 ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor for the HLAST-in-TUSER instance: scoreboard pops and stall hold.
  logic  stall0 = 1'b0;
  beat_t held0, got0;
  always @(negedge clk) begin
    if (!rstN) begin
      stall0 = 1'b0;
    end else begin
      if (stall0) begin
        checkOutput("m0 hold valid", 32'(m0Valid), 32'd1);
        checkOutput("m0 hold data", 32'(m0Data), 32'(held0.data));
        checkOutput("m0 hold last", 32'(m0Last), 32'(held0.last));
        checkOutput("m0 hold user", 32'(m0User), 32'(held0.user));
      end
      if (m0Valid && !m0Ready) checkOutput("s0 ready in stall", 32'(s0Ready), 32'd0);
      if (m0Valid && m0Ready) begin
        if (exp0.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL m0 unexpected output actual=%0h required=none", m0Data);
        end else begin
          got0 = exp0.pop_front();
          checkOutput("m0 data", 32'(m0Data), 32'(got0.data));
          checkOutput("m0 last", 32'(m0Last), 32'(got0.last));
          checkOutput("m0 user", 32'(m0User), 32'(got0.user));
        end
      end
      stall0 = m0Valid && !m0Ready;
      held0  = '{m0Data, m0Last, m0User};
    end
  end

  // Monitor for the SOF-in-TUSER instance.
  logic  stall1 = 1'b0;
  beat_t held1, got1;
  always @(negedge clk) begin
    if (!rstN) begin
      stall1 = 1'b0;
    end else begin
      if (stall1) begin
        checkOutput("m1 hold valid", 32'(m1Valid), 32'd1);
        checkOutput("m1 hold data", 32'(m1Data), 32'(held1.data));
        checkOutput("m1 hold last", 32'(m1Last), 32'(held1.last));
        checkOutput("m1 hold user", 32'(m1User), 32'(held1.user));
      end
      if (m1Valid && !m1Ready) checkOutput("s1 ready in stall", 32'(s1Ready), 32'd0);
      if (m1Valid && m1Ready) begin
        outCount1++;
        if (exp1.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL m1 unexpected output actual=%0h required=none", m1Data);
        end else begin
          got1 = exp1.pop_front();
          checkOutput("m1 data", 32'(m1Data), 32'(got1.data));
          checkOutput("m1 last", 32'(m1Last), 32'(got1.last));
          checkOutput("m1 user", 32'(m1User), 32'(got1.user));
        end
      end
      stall1 = m1Valid && !m1Ready;
      held1  = '{m1Data, m1Last, m1User};
    end
  end

  // Drive one input beat and hold it until accepted (bounded).
  task automatic applyStimulus(input int inst, input logic [PW-1:0] data,
                               input logic last, input logic user);
    bit acc;
    int waited;
    if (gapOn && $urandom_range(0, 3) == 0) begin
      @(posedge clk);
      #1;
    end
    if (inst == 0) begin
      s0Valid = 1'b1; s0Data = data; s0Last = last; s0User = user;
    end else begin
      s1Valid = 1'b1; s1Data = data; s1Last = last; s1User = user;
    end
    acc = 1'b0;
    waited = 0;
    while (!acc && waited < 200) begin
      @(negedge clk);
      acc = (inst == 0) ? s0Ready : s1Ready;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("[TB] FAIL input accept timeout inst=%0d actual=stalled required=accepted", inst);
    end
    if (inst == 0) s0Valid = 1'b0;
    else s1Valid = 1'b0;
  endtask

  function automatic void setLens(input int w, input int h);
    lineLens.delete();
    for (int i = 0; i < h; i++) lineLens.push_back(w);
  endfunction

  // Send one frame described by lineLens: the reference model derives the
  // expected cropped beats and error outcome from the window arithmetic,
  // then the frame is driven beat by beat.
  task automatic sendFrame(input int inst, input int xoff, input int yoff, input int w,
                           input int h, input int chgX, input int chgY, input int chgW,
                           input int beatLimit);
    logic [PW-1:0] pix[$];
    int            n, total, idx, xe, ye, len;
    bit            ok, dropped, lastB, userB;
    beat_t         e;
    n = lineLens.size();
    total = 0;
    foreach (lineLens[i]) total += lineLens[i];
    for (int i = 0; i < total; i++) pix.push_back(PW'($urandom()));

    xe = xoff + w;
    ye = yoff + h;
    ok = (w != 0) && (h != 0);
    dropped = 1'b0;
    idx = 0;
    if (inst == 1 && pendShort1) expErr1 = 1'b1;
    for (int y = 0; y < n; y++) begin
      len = lineLens[y];
      for (int x = 0; x < len; x++) begin
        if (idx < beatLimit && !dropped && ok && x >= xoff && x < xe && y >= yoff && y < ye) begin
          e.data = pix[idx];
          if (inst == 0) begin
            e.user = (x == xe - 1);
            e.last = (x == xe - 1) && (y == ye - 1);
            exp0.push_back(e);
          end else begin
            e.user = (x == xoff) && (y == yoff);
            e.last = (x == xe - 1);
            exp1.push_back(e);
          end
        end
        idx++;
      end
      if (idx <= beatLimit && !dropped && ok && y >= yoff && y < ye && len < xe) begin
        dropped = 1'b1;
        if (inst == 0) expErr0 = 1'b1;
        else expErr1 = 1'b1;
      end
    end
    if (inst == 0) begin
      if (idx <= beatLimit && !dropped && ok && n < ye) expErr0 = 1'b1;
    end else begin
      pendShort1 = !dropped && ok && n < ye;
    end

    if (inst == 0) begin
      xoff0 = LGDIM'(xoff); yoff0 = LGDIM'(yoff); width0 = LGDIM'(w); height0 = LGDIM'(h);
    end else begin
      xoff1 = LGDIM'(xoff); yoff1 = LGDIM'(yoff); width1 = LGDIM'(w); height1 = LGDIM'(h);
    end
    idx = 0;
    for (int y = 0; y < n; y++) begin
      for (int x = 0; x < lineLens[y]; x++) begin
        if (idx < beatLimit) begin
          if (x == chgX && y == chgY) begin
            if (inst == 0) width0 = LGDIM'(chgW);
            else width1 = LGDIM'(chgW);
          end
          if (inst == 0) begin
            userB = (x == lineLens[y] - 1);
            lastB = userB && (y == n - 1);
          end else begin
            userB = (x == 0) && (y == 0);
            lastB = (x == lineLens[y] - 1);
          end
          applyStimulus(inst, pix[idx], lastB, userB);
        end
        idx++;
      end
    end
  endtask

  // Wait (bounded) for a scoreboard to empty, then let the output settle.
  task automatic drain(input int inst);
    int waited = 0;
    while (((inst == 0) ? exp0.size() : exp1.size()) != 0 && waited < 1000) begin
      @(posedge clk);
      waited++;
    end
    if (((inst == 0) ? exp0.size() : exp1.size()) != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain timeout inst=%0d actual=%0d pending required=0", inst,
               (inst == 0) ? exp0.size() : exp1.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic checkReset();
    @(negedge clk);
    checkOutput("reset m0 valid", 32'(m0Valid), 32'd0);
    checkOutput("reset m0 last", 32'(m0Last), 32'd0);
    checkOutput("reset m0 user", 32'(m0User), 32'd0);
    checkOutput("reset err0", 32'(err0), 32'd0);
    checkOutput("reset m1 valid", 32'(m1Valid), 32'd0);
    checkOutput("reset m1 last", 32'(m1Last), 32'd0);
    checkOutput("reset m1 user", 32'(m1User), 32'd0);
    checkOutput("reset err1", 32'(err1), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w, h, xo, yo, cw, ch;
    rstN = 1'b0;
    repeat (3) @(posedge clk);
    checkReset();
    @(posedge clk);
    #1;
    rstN = 1'b1;

    $display("[TB] pass-through 8x4");
    setLens(8, 4);
    sendFrame(0, 0, 0, 8, 4, -1, -1, 0, 1 << 30);
    drain(0);
    checkOutput("err pass-through", 32'(err0), 32'(expErr0));

    $display("[TB] centre crop");
    sendFrame(0, 2, 1, 3, 2, -1, -1, 0, 1 << 30);
    drain(0);
    checkOutput("err centre crop", 32'(err0), 32'd0);

    $display("[TB] centre crop with backpressure");
    bp0 = 1'b1;
    gapOn = 1'b1;
    sendFrame(0, 2, 1, 3, 2, -1, -1, 0, 1 << 30);
    drain(0);
    bp0 = 1'b0;
    gapOn = 1'b0;

    $display("[TB] mid-frame config change");
    sendFrame(0, 2, 1, 3, 2, 5, 2, 2, 1 << 30);
    sendFrame(0, 2, 1, 2, 2, -1, -1, 0, 1 << 30);
    drain(0);
    checkOutput("err config change", 32'(err0), 32'd0);

    $display("[TB] short line");
    lineLens = '{8, 4, 8, 8};
    sendFrame(0, 2, 1, 3, 2, -1, -1, 0, 1 << 30);
    setLens(8, 4);
    sendFrame(0, 2, 1, 3, 2, -1, -1, 0, 1 << 30);
    drain(0);
    checkOutput("err short line", 32'(err0), 32'(expErr0));

    $display("[TB] random frames");
    bp0 = 1'b1;
    gapOn = 1'b1;
    for (int f = 0; f < 10; f++) begin
      w  = $urandom_range(1, 10);
      h  = $urandom_range(1, 5);
      lineLens.delete();
      for (int i = 0; i < h; i++)
        lineLens.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(1, w) : w);
      xo = $urandom_range(0, w - 1);
      cw = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, w - xo + 1);
      yo = $urandom_range(0, h - 1);
      ch = $urandom_range(1, h - yo + 1);
      sendFrame(0, xo, yo, cw, ch, -1, -1, 0, 1 << 30);
    end
    drain(0);
    checkOutput("err random", 32'(err0), 32'(expErr0));
    bp0 = 1'b0;

    $display("[TB] reset mid-frame");
    setLens(8, 4);
    sendFrame(0, 0, 0, 0, 4, -1, -1, 0, 10);
    bp0 = 1'b1;
    rstN = 1'b0;
    expErr0 = 1'b0;
    expErr1 = 1'b0;
    repeat (2) @(posedge clk);
    checkReset();
    @(posedge clk);
    #1;
    rstN = 1'b1;
    bp0 = 1'b0;
    sendFrame(0, 2, 1, 3, 2, -1, -1, 0, 1 << 30);
    drain(0);
    checkOutput("err after reset", 32'(err0), 32'(expErr0));

    $display("[TB] SOF mode: beats before first SOF");
    for (int i = 0; i < 5; i++)
      applyStimulus(1, PW'($urandom()), 1'($urandom_range(0, 1)), 1'b0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("m1 beats before SOF", 32'(outCount1), 32'd0);

    $display("[TB] SOF mode: 4x2 full crop");
    setLens(4, 2);
    sendFrame(1, 0, 0, 4, 2, -1, -1, 0, 1 << 30);
    drain(1);
    checkOutput("m1 full crop count", 32'(outCount1), 32'd8);

    $display("[TB] SOF mode: random frames");
    bp1 = 1'b1;
    gapOn = 1'b1;
    for (int f = 0; f < 6; f++) begin
      w  = $urandom_range(1, 9);
      h  = $urandom_range(1, 4);
      setLens(w, h);
      xo = $urandom_range(0, w - 1);
      cw = $urandom_range(1, w - xo);
      yo = $urandom_range(0, h - 1);
      ch = $urandom_range(1, h - yo);
      sendFrame(1, xo, yo, cw, ch, -1, -1, 0, 1 << 30);
    end
    drain(1);
    checkOutput("err1 random", 32'(err1), 32'(expErr1));
    bp1 = 1'b0;
    gapOn = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
